// File: rtl/bytecode_sequencer.sv
// Java bytecode fetch sequencer: reads opcode/operand bytes from a ROM and hands
// each decoded instruction to an ARM translator, halting on the return opcode.
module bytecode_sequencer #(
    parameter int          ADDR_W     = 10,
    parameter logic [7:0]  END_OPCODE = 8'hB1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [7:0]        tr_opcode,
    output logic [7:0]        tr_op1,
    output logic [7:0]        tr_op2,
    output logic [1:0]        tr_nops,
    input  logic              tr_done,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_OP, S_WAIT_OP, S_FETCH_OPND,
        S_WAIT_OPND, S_ISSUE, S_WAIT_DONE, S_HALT
    } state_t;

    localparam logic [ADDR_W:0] PC_ONE = {{ADDR_W{1'b0}}, 1'b1};

    function automatic logic [1:0] opnd_count(input logic [7:0] op);
        logic [1:0] n;
        case (op)
            8'h10, 8'h15, 8'h36: n = 2'd1;
            8'h11, 8'h84:        n = 2'd2;
            default:             n = (op >= 8'h99 && op <= 8'hA7) ? 2'd2 : 2'd0;
        endcase
        return n;
    endfunction

    state_t          r_state;
    state_t          w_next;
    // One extra pc bit records that the address space has been exhausted.
    logic [ADDR_W:0] r_pc;
    logic            r_opnd_idx;
    logic            r_err;
    logic [7:0]      r_opcode;
    logic [7:0]      r_op1;
    logic [7:0]      r_op2;
    logic [1:0]      r_nops;
    logic            w_wrapped;
    logic            w_fetch;

    assign w_wrapped = r_pc[ADDR_W];
    assign w_fetch   = (r_state == S_FETCH_OP) || (r_state == S_FETCH_OPND);

    // NOTE: reset lives inside the clocked block, so it is synchronous; all state uses <=.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (start) w_next = S_FETCH_OP;
            S_FETCH_OP:     w_next = w_wrapped ? S_HALT : S_WAIT_OP;
            S_WAIT_OP:      w_next = (opnd_count(rom_data) != 2'd0) ? S_FETCH_OPND : S_ISSUE;
            S_FETCH_OPND:   w_next = w_wrapped ? S_HALT : S_WAIT_OPND;
            S_WAIT_OPND:    w_next = (!r_opnd_idx && r_nops == 2'd2) ? S_FETCH_OPND : S_ISSUE;
            S_ISSUE:        if (tr_ready) w_next = S_WAIT_DONE;
            S_WAIT_DONE:    if (tr_done) w_next = (r_opcode == END_OPCODE) ? S_HALT : S_FETCH_OP;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= '0;
            r_opnd_idx <= 1'b0;
            r_err      <= 1'b0;
            r_opcode   <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_nops     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc  <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_FETCH_OP, S_FETCH_OPND: begin
                    if (w_wrapped) r_err <= 1'b1;
                    else           r_pc  <= r_pc + PC_ONE;
                end
                S_WAIT_OP: begin
                    r_opcode   <= rom_data;
                    r_op1      <= '0;
                    r_op2      <= '0;
                    r_nops     <= opnd_count(rom_data);
                    r_opnd_idx <= 1'b0;
                end
                S_WAIT_OPND: begin
                    if (!r_opnd_idx) r_op1 <= rom_data;
                    else             r_op2 <= rom_data;
                    r_opnd_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rom_en    = w_fetch && !w_wrapped;
    assign rom_addr  = r_pc[ADDR_W-1:0];
    assign tr_valid  = (r_state == S_ISSUE);
    assign tr_opcode = r_opcode;
    assign tr_op1    = r_op1;
    assign tr_op2    = r_op2;
    assign tr_nops   = r_nops;
    assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted    = (r_state == S_HALT);
    assign err       = r_err;

endmodule

// File: tb/tb_bytecode_sequencer.sv
// Scoreboard bench for bytecode_sequencer: ROM and translator models, expected
// requests queued per program and compared as each transfer happens.
module tb_bytecode_sequencer;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] o1;
        logic [7:0] o2;
        logic [1:0] n;
    } req_t;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       rom_en;
    logic [9:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic       tr_valid, tr_ready = 1'b1, tr_done = 1'b0;
    logic [7:0] tr_opcode, tr_op1, tr_op2;
    logic [1:0] tr_nops;
    logic       busy, halted, err;

    logic       s_start;
    logic       s_rom_en;
    logic [1:0] s_rom_addr;
    logic [7:0] s_rom_data = 8'h00;
    logic       s_tr_valid, s_tr_done = 1'b0;
    logic       s_tr_ready;
    logic [7:0] s_tr_opcode, s_tr_op1, s_tr_op2;
    logic [1:0] s_tr_nops;
    logic       s_busy, s_halted, s_err;

    logic [7:0] rom [0:1023];
    logic [7:0] s_rom [0:3];
    logic [7:0] prog [$];
    req_t       exp_q [$];

    int checks = 0, failures = 0;
    int tid = 0, last_tid = 0, stall_total = 0, stall_seen = 0;
    logic glitch_done = 1'b0, done_next = 1'b0, s_done_next = 1'b0;
    int s_issues = 0;
    int lat;
    req_t head;

    always #5 clk = ~clk;

    bytecode_sequencer #(.ADDR_W(10)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_opcode(tr_opcode),
        .tr_op1(tr_op1), .tr_op2(tr_op2), .tr_nops(tr_nops), .tr_done(tr_done),
        .busy(busy), .halted(halted), .err(err)
    );

    bytecode_sequencer #(.ADDR_W(2)) u_dut_small (
        .clk(clk), .reset(reset), .start(s_start),
        .rom_en(s_rom_en), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
        .tr_valid(s_tr_valid), .tr_ready(s_tr_ready), .tr_opcode(s_tr_opcode),
        .tr_op1(s_tr_op1), .tr_op2(s_tr_op2), .tr_nops(s_tr_nops), .tr_done(s_tr_done),
        .busy(s_busy), .halted(s_halted), .err(s_err)
    );

    assign s_tr_ready = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic req_t mk(input logic [7:0] op, input logic [7:0] o1,
                                input logic [7:0] o2, input logic [1:0] n);
        req_t r;
        r.op = op; r.o1 = o1; r.o2 = o2; r.n = n;
        return r;
    endfunction

    task automatic load_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
        for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
    endtask

    // ROM models: byte valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (rom_en)   rom_data   <= rom[rom_addr];
        if (s_rom_en) s_rom_data <= s_rom[s_rom_addr];
    end

    // Translator model and scoreboard for the main instance.
    always @(negedge clk) begin
        if (tid != last_tid) begin
            last_tid   = tid;
            stall_seen = 0;
        end
        tr_done   = done_next;
        done_next = 1'b0;
        if (tr_valid && stall_seen < stall_total) begin
            tr_ready = 1'b0;
            stall_seen++;
            if (glitch_done) tr_done = 1'b1;
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                check("stall_valid", tr_valid, 1'b1);
                check("stall_op", tr_opcode, head.op);
                check("stall_op1", tr_op1, head.o1);
                check("stall_op2", tr_op2, head.o2);
                check("stall_nops", tr_nops, head.n);
            end
        end else begin
            tr_ready = 1'b1;
        end
        if (tr_valid && tr_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", tr_opcode, 32'hFFFF_FFFF);
            end else begin
                head = exp_q.pop_front();
                check("req_op", tr_opcode, head.op);
                check("req_op1", tr_op1, head.o1);
                check("req_op2", tr_op2, head.o2);
                check("req_nops", tr_nops, head.n);
            end
            done_next = 1'b1;
        end
    end

    // Translator model for the narrow-address instance: every request must be 03.
    always @(negedge clk) begin
        s_tr_done   = s_done_next;
        s_done_next = 1'b0;
        if (s_tr_valid) begin
            check("small_op", s_tr_opcode, 8'h03);
            s_issues++;
            s_done_next = 1'b1;
        end
    end

    task automatic start_run(output int latency);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        latency = 1;
        while (!tr_valid && latency < 40) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!halted && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; s_start = 1'b0;
        s_rom[0] = 8'h03; s_rom[1] = 8'h03; s_rom[2] = 8'h03; s_rom[3] = 8'h10;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", tr_valid, 1'b0);
        check("rst_rom_en", rom_en, 1'b0);
        check("rst_rom_addr", rom_addr, 10'd0);
        check("rst_busy_halt_err", {busy, halted, err}, 3'b000);
        check("rst_payload", {tr_opcode, tr_op1, tr_op2, tr_nops}, 26'd0);
        reset = 1'b1;

        // Three zero-operand opcodes ending in return.
        tid = 1; stall_total = 0;
        prog = '{8'h04, 8'h3C, 8'hB1}; load_rom();
        exp_q.push_back(mk(8'h04, 8'h00, 8'h00, 2'd0));
        exp_q.push_back(mk(8'h3C, 8'h00, 8'h00, 2'd0));
        exp_q.push_back(mk(8'hB1, 8'h00, 8'h00, 2'd0));
        start_run(lat);
        check("lat_0op", lat, 3);
        wait_halt();
        check("t1_status", {busy, halted, err}, 3'b010);
        check("t1_drained", exp_q.size(), 0);

        // Two-operand opcode latency and payload.
        tid = 2;
        prog = '{8'h11, 8'h12, 8'h34, 8'hB1}; load_rom();
        exp_q.push_back(mk(8'h11, 8'h12, 8'h34, 2'd2));
        exp_q.push_back(mk(8'hB1, 8'h00, 8'h00, 2'd0));
        start_run(lat);
        check("lat_2op", lat, 7);
        wait_halt();
        check("t2_err", err, 1'b0);
        check("t2_drained", exp_q.size(), 0);

        // Operand-count table edges, backpressure, stray tr_done and start while busy.
        tid = 3; stall_total = 5; glitch_done = 1'b1;
        prog = '{8'h15, 8'h7F, 8'hA7, 8'h01, 8'h02, 8'h98, 8'h99, 8'hAA, 8'hBB,
                 8'hA8, 8'h36, 8'h05, 8'h84, 8'h03, 8'h04, 8'hB1};
        load_rom();
        exp_q.push_back(mk(8'h15, 8'h7F, 8'h00, 2'd1));
        exp_q.push_back(mk(8'hA7, 8'h01, 8'h02, 2'd2));
        exp_q.push_back(mk(8'h98, 8'h00, 8'h00, 2'd0));
        exp_q.push_back(mk(8'h99, 8'hAA, 8'hBB, 2'd2));
        exp_q.push_back(mk(8'hA8, 8'h00, 8'h00, 2'd0));
        exp_q.push_back(mk(8'h36, 8'h05, 8'h00, 2'd1));
        exp_q.push_back(mk(8'h84, 8'h03, 8'h04, 2'd2));
        exp_q.push_back(mk(8'hB1, 8'h00, 8'h00, 2'd0));
        start_run(lat);
        check("lat_1op", lat, 5);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_halt();
        glitch_done = 1'b0;
        check("t3_stall_cycles", stall_seen, 5);
        check("t3_err", err, 1'b0);
        check("t3_drained", exp_q.size(), 0);

        // Reset while a request is pending, then a clean rerun.
        tid = 4; stall_total = 20;
        prog = '{8'h04, 8'hB1}; load_rom();
        exp_q.push_back(mk(8'h04, 8'h00, 8'h00, 2'd0));
        exp_q.push_back(mk(8'hB1, 8'h00, 8'h00, 2'd0));
        start_run(lat);
        check("t4_in_issue", tr_valid, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("t4_rst_valid", tr_valid, 1'b0);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_payload", {tr_opcode, tr_nops}, 10'd0);
        tid = 5; stall_total = 0;
        exp_q.delete();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_stays_idle", {busy, halted, tr_valid}, 3'b000);
        exp_q.push_back(mk(8'h04, 8'h00, 8'h00, 2'd0));
        exp_q.push_back(mk(8'hB1, 8'h00, 8'h00, 2'd0));
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("t4_refetch_en", rom_en, 1'b1);
        check("t4_refetch_addr", rom_addr, 10'd0);
        wait_halt();
        check("t4_drained", exp_q.size(), 0);

        // Narrow address space with no return opcode: the wrap must end the run.
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        for (int n = 0; n < 100 && !s_halted; n++) begin
            @(posedge clk); #1;
        end
        check("small_halted", s_halted, 1'b1);
        check("small_err", s_err, 1'b1);
        check("small_busy", s_busy, 1'b0);
        repeat (3) @(posedge clk);
        check("small_issues", s_issues, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bytecode_sequencer.md
BYTECODE_SEQUENCER -- requirements
Module: bytecode_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, bytecode ROM address width.
REQ-002 SHALL have parameter END_OPCODE, default 8'hB1 (return), the last bytecode of a program.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-low: 0 at a clk edge resets.
REQ-005 SHALL have port start, input, 1, begins a program run from address 0.
REQ-006 SHALL have port rom_en, output, 1, ROM read strobe.
REQ-007 SHALL have port rom_addr, output, ADDR_W, ROM read address.
REQ-008 SHALL have port rom_data, input, 8, ROM byte, valid the cycle after rom_en.
REQ-009 SHALL have port tr_valid, output, 1, translation request to the ARM-emitting translator.
REQ-010 SHALL have port tr_ready, input, 1, translator accepts request.
REQ-011 SHALL have port tr_opcode, output, 8, Java opcode.
REQ-012 SHALL have ports tr_op1 and tr_op2, output, 8 each, first and second operand bytes.
REQ-013 SHALL have port tr_nops, output, 2, operand count (0..2).
REQ-014 SHALL have port tr_done, input, 1, translator finished emitting ARM words.
REQ-015 SHALL have ports busy, halted and err, output, 1 each, run status.

Function
REQ-016 SHALL implement states IDLE, FETCH_OP, WAIT_OP, FETCH_OPND, WAIT_OPND, ISSUE, WAIT_DONE, HALT.
REQ-017 SHALL set operand count: 8'h10, 8'h15, 8'h36 -> 1; 8'h11, 8'h84, 8'h99..8'hA7 -> 2; all others -> 0.
REQ-018 IDLE or HALT with start=1 SHALL clear pc to 0, clear err and halted, go to FETCH_OP.
REQ-019 FETCH_OP and FETCH_OPND SHALL drive rom_en=1 and rom_addr=pc for exactly one cycle, pc+1 on the same edge.
REQ-020 WAIT_OP SHALL capture rom_data into tr_opcode, zero tr_op1/tr_op2, set tr_nops; next state FETCH_OPND if nops>0, else ISSUE.
REQ-021 WAIT_OPND SHALL capture rom_data into tr_op1 (first operand) or tr_op2 (second); next state FETCH_OPND until all operands are captured, then ISSUE.
REQ-022 Latency: start in IDLE to tr_valid SHALL be 3 cycles for a 0-operand opcode, plus 2 cycles per operand.
REQ-023 ISSUE SHALL hold tr_valid=1 with tr_opcode/tr_op1/tr_op2/tr_nops stable until tr_ready=1; transfer on tr_valid&&tr_ready, then WAIT_DONE with tr_valid=0.
REQ-024 WAIT_DONE with tr_done=1 SHALL go to HALT if tr_opcode==END_OPCODE, else to FETCH_OP.
REQ-025 tr_done outside WAIT_DONE and tr_ready outside ISSUE SHALL be ignored.
REQ-026 start outside IDLE/HALT SHALL be ignored.
REQ-027 A fetch needed when pc wrapped past 2^ADDR_W-1 SHALL not be issued: go to HALT with err=1, no tr_valid for the partial instruction.
REQ-028 busy SHALL be 1 in every state except IDLE and HALT; halted SHALL be 1 only in HALT.
REQ-029 rom_en SHALL be 0 in all states other than FETCH_OP/FETCH_OPND.

Reset
REQ-030 reset=0 at a clk edge SHALL force IDLE, pc=0, rom_en=0, rom_addr=0, tr_valid=0, tr_opcode=tr_op1=tr_op2=0, tr_nops=0, busy=0, halted=0, err=0, overriding all other inputs.
REQ-031 reset mid-operation (including ISSUE with tr_valid=1) SHALL drop tr_valid the next cycle and abandon the instruction; start is required to rerun.

Verification
REQ-032 ROM {04,3C,B1}, tr_ready=1, tr_done 1 cycle after each transfer -> three requests with opcodes 04, 3C, B1, all nops=0; then halted=1, busy=0, err=0.
REQ-033 ROM {11,12,34,B1} -> first request tr_opcode=11, tr_op1=12, tr_op2=34, tr_nops=2, tr_valid at cycle 7 after start.
REQ-034 tr_ready held 0 for 5 cycles in ISSUE -> tr_valid and payload constant all 5 cycles; exactly one transfer when tr_ready rises.
REQ-035 ADDR_W=2, ROM {03,03,03,10} (no END) -> three issues of 03, then err=1, halted=1, no fourth tr_valid.
REQ-036 reset=0 while in ISSUE -> next cycle tr_valid=0, busy=0; start pulse after reset refetches from rom_addr=0.
REQ-037 start pulsed while busy and tr_done pulsed in ISSUE -> no restart and no state advance; run completes normally.
